kbd_voice_alloc: RTL and testbench
==================================

Name: kbd_voice_alloc

Overview:
- Polyphonic voice allocator directly downstream of the PS/2 keyboard decoder.
- Consumes the 13-bit piano-key bitmask (bits 0..12, C..C') and assigns held keys to NVOICES synthesis voices.
- Drives per-voice note index, gate and one-cycle retrigger pulses into the wavetable oscillator/envelope bank.
- When every voice is busy, the oldest voice is stolen.

Parameters:
NVOICES, 4, number of voices; legal range 2..8
NKEYS, 13, number of key bits scanned; legal range 2..16

Ports:
clk  in  1  system clock
ar  in  1  asynchronous reset, active-high
key_mask  in  NKEYS  key-held bitmask from the keyboard decoder; launched from the PS/2 filtered-clock domain, so treated as asynchronous
voice_note  out  4*NVOICES  voice v note index at bits [4v+3:4v]
voice_gate  out  NVOICES  voice v currently sounding
voice_trig  out  NVOICES  one-cycle pulse when voice v receives a new note (fresh or stolen)
steal  out  1  one-cycle pulse coincident with voice_trig when the allocation stole a busy voice
active_count  out  4  number of voices with gate=1

Behaviour:
- Reset (ar=1, asynchronous) clears all registers:
  - voice_note=0, voice_gate=0, voice_trig=0, steal=0, active_count=0.
  - Synchronizer flops, held[] key record, scan pointer kptr=0 and all voice ages cleared.
- Reset asserted mid-operation drops all gates immediately. Keys still down after reset release are detected as fresh presses on the next scan.
- Sync: key_mask passes through a 2-flop synchronizer to km_s. No other logic uses key_mask directly.
- Scan:
  - kptr steps 0..NKEYS-1 and wraps to 0, one key per clk, free-running.
  - Each cycle, km_s[kptr] is compared with held[kptr]. Exactly one key event is processed per cycle, so simultaneous presses are serialized in ascending key order.
- Press (km_s=1, held=0):
  - held[kptr]<=1.
  - If any voice has gate=0, the lowest-index free voice v is selected.
  - Otherwise the voice with the largest age is stolen; ties go to the lowest index.
  - On the next edge: note[v]<=kptr, gate[v]<=1, trig[v]=1 for exactly that one cycle, steal=1 for that cycle if stolen.
  - age[v]<=0. Every other gated voice's age increments, saturating at NVOICES-1.
- Release (km_s=0, held=1):
  - held[kptr]<=0.
  - Any voice with gate=1 and note==kptr gets gate<=0; its note is retained for the envelope release tail.
  - If the key had been stolen, no voice matches and nothing else changes.
- Stolen key: its held bit stays 1, so it is not reallocated until released and pressed again.
- No change (km_s==held): no output change; trig/steal=0.
- Ages: 3 bits per voice. A free voice's age is don't-care but is reset to 0 on allocation.
- active_count: registered popcount of voice_gate, updated the same edge as the gates. Range 0..NVOICES.
- Latency:
  - Key edge to gate/trig: 2 sync cycles + 0..NKEYS-1 scan wait + 1 register cycle, i.e. ≤ NKEYS+2 clks.
  - A key pressed and released within one scan period may be missed. This is acceptable because PS/2 scan rates are orders of magnitude slower.
- Outputs are all registered; there are no combinational paths from key_mask.
- Invariant: at most one gated voice per note index.

Test Plan:
- Reset then key_mask=0x0001 → within 15 clks voice_note[3:0]=0, voice_gate=0001, one trig=0001 pulse, steal=0, active_count=1; hold 50 clks → no further trig.
- key_mask=0x0015 applied at once (keys 0,2,4) → voices 0,1,2 get notes 0,2,4 in that order on successive scan cycles, gate=0111, three separate single-cycle trig pulses, active_count=3.
- Press keys 1,3,5,7 one after another, then key 9 → voices hold 1,3,5,7; key 9 steals voice 0 (oldest): note0=9, trig=0001, steal=1, gate=1111, active_count=4.
- From the prior state, release key 1 (stolen) → no change. Release key 9 → gate0 clears, note0 stays 9, active_count=3.
- Press key 0x0C then release it → voice gated with note 12; after release, gate=0 within ≤15 clks. Re-press → same voice 0 reallocated with trig.
- Keys 0,2 held, ar pulsed 1 cycle mid-scan → all outputs 0 immediately; after release both keys reallocated to voices 0,1 with trig pulses.

Source files
------------

// File: rtl/kbd_voice_alloc.sv
// Polyphonic voice allocator: scans a synchronised key bitmask and assigns held keys to voices, stealing the oldest when full.
// Latency: key edge to gate/trig is 2 sync cycles + 0..NKEYS-1 scan wait + 1 register cycle (<= NKEYS+2 clks).
// Backpressure: none; one key event per cycle, and a press/release shorter than one scan period may be missed.
module kbd_voice_alloc #(
    parameter int NVOICES = 4,
    parameter int NKEYS   = 13
) (
    input  logic                   clk,
    input  logic                   ar,
    input  logic [NKEYS-1:0]       key_mask,
    output logic [4*NVOICES-1:0]   voice_note,
    output logic [NVOICES-1:0]     voice_gate,
    output logic [NVOICES-1:0]     voice_trig,
    output logic                   steal,
    output logic [3:0]             active_count
);

    localparam int         KW      = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int         VW      = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam logic [2:0] AGE_MAX = 3'(NVOICES - 1);

    logic [NKEYS-1:0]     km_m;
    logic [NKEYS-1:0]     km_s;
    logic [NKEYS-1:0]     held;
    logic [NKEYS-1:0]     held_nxt;
    logic [KW-1:0]        kptr;
    logic [3:0]           kptr_note;
    logic [2:0]           age     [NVOICES];
    logic [2:0]           age_nxt [NVOICES];

    logic                 press_ev;
    logic                 rel_ev;
    logic                 any_free;
    logic [VW-1:0]        free_idx;
    logic [VW-1:0]        old_idx;
    logic [2:0]           old_age;
    logic [VW-1:0]        alloc_idx;

    logic [4*NVOICES-1:0] note_nxt;
    logic [NVOICES-1:0]   gate_nxt;
    logic [NVOICES-1:0]   trig_nxt;
    logic                 steal_nxt;
    logic [3:0]           cnt_nxt;

    assign kptr_note = 4'(kptr);
    assign press_ev  = km_s[kptr] & ~held[kptr];
    assign rel_ev    = ~km_s[kptr] & held[kptr];

    // Two-flop synchroniser: key_mask comes from the PS/2 filtered-clock domain.
    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            km_m <= '0;
            km_s <= '0;
        end else begin
            km_m <= key_mask;
            km_s <= km_m;
        end
    end

    // Free-running scan pointer, one key per cycle, wrapping at NKEYS-1.
    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            kptr <= '0;
        end else if (kptr == KW'(NKEYS - 1)) begin
            kptr <= '0;
        end else begin
            kptr <= kptr + 1'b1;
        end
    end

    // Victim selection: lowest free voice, else oldest gated voice with ties to the lowest index.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        old_idx  = '0;
        old_age  = age[0];
        for (int v = NVOICES - 1; v >= 0; v--) begin
            if (!voice_gate[v]) begin
                any_free = 1'b1;
                free_idx = VW'(v);
            end
        end
        for (int v = 1; v < NVOICES; v++) begin
            if (age[v] > old_age) begin
                old_age = age[v];
                old_idx = VW'(v);
            end
        end
        alloc_idx = any_free ? free_idx : old_idx;
    end

    // Next state for the scanned key: allocate on press, drop the matching gate on release.
    always_comb begin
        held_nxt  = held;
        note_nxt  = voice_note;
        gate_nxt  = voice_gate;
        trig_nxt  = '0;
        steal_nxt = 1'b0;
        age_nxt   = age;
        if (press_ev) begin
            held_nxt[kptr] = 1'b1;
            steal_nxt      = ~any_free;
            for (int v = 0; v < NVOICES; v++) begin
                if (VW'(v) == alloc_idx) begin
                    note_nxt[4*v +: 4] = kptr_note;
                    gate_nxt[v]        = 1'b1;
                    trig_nxt[v]        = 1'b1;
                    age_nxt[v]         = 3'd0;
                end else if (voice_gate[v] && (age[v] != AGE_MAX)) begin
                    age_nxt[v] = age[v] + 3'd1;
                end
            end
        end else if (rel_ev) begin
            // A stolen key matches no voice, so its release changes only held.
            held_nxt[kptr] = 1'b0;
            for (int v = 0; v < NVOICES; v++) begin
                if (voice_gate[v] && (voice_note[4*v +: 4] == kptr_note)) begin
                    gate_nxt[v] = 1'b0;
                end
            end
        end
    end

    // Population count of the next gate vector, so active_count tracks gates in the same edge.
    always_comb begin
        cnt_nxt = '0;
        for (int v = 0; v < NVOICES; v++) begin
            cnt_nxt = cnt_nxt + 4'(gate_nxt[v]);
        end
    end

    // Voice state and registered outputs.
    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            held         <= '0;
            voice_note   <= '0;
            voice_gate   <= '0;
            voice_trig   <= '0;
            steal        <= 1'b0;
            active_count <= '0;
            for (int v = 0; v < NVOICES; v++) begin
                age[v] <= 3'd0;
            end
        end else begin
            held         <= held_nxt;
            voice_note   <= note_nxt;
            voice_gate   <= gate_nxt;
            voice_trig   <= trig_nxt;
            steal        <= steal_nxt;
            active_count <= cnt_nxt;
            for (int v = 0; v < NVOICES; v++) begin
                age[v] <= age_nxt[v];
            end
        end
    end

endmodule

// File: tb/tb_kbd_voice_alloc.sv
// Bench for kbd_voice_alloc: table of key-mask steps with expected trig events and settled voice state.
// Latency: each step allows 16 clks for all expected trig events, then checks gates, notes and count.
// Backpressure: none; a scoreboard queue receives expected trig events and the monitor pops them as pulses appear.
module tb_kbd_voice_alloc;

    localparam int NV = 4;
    localparam int NK = 13;

    logic              clk = 1'b0;
    logic              ar  = 1'b1;
    logic [NK-1:0]     key_mask = '0;
    logic [4*NV-1:0]   voice_note;
    logic [NV-1:0]     voice_gate;
    logic [NV-1:0]     voice_trig;
    logic              steal;
    logic [3:0]        active_count;

    kbd_voice_alloc #(.NVOICES(NV), .NKEYS(NK)) dut (
        .clk          (clk),
        .ar           (ar),
        .key_mask     (key_mask),
        .voice_note   (voice_note),
        .voice_gate   (voice_gate),
        .voice_trig   (voice_trig),
        .steal        (steal),
        .active_count (active_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] v;
        logic [3:0] n;
        logic       s;
    } ev_t;

    typedef struct packed {
        logic [NK-1:0] km;
        logic [1:0]    nev;
        ev_t           e0;
        ev_t           e1;
        ev_t           e2;
        logic [15:0]   notes;
        logic [3:0]    gate;
        logic [3:0]    cnt;
    } step_t;

    int    checks = 0;
    int    fails  = 0;
    int    cyc;
    logic  mon_en = 1'b0;
    ev_t   exp_q[$];
    ev_t   got;
    step_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic ev_t ev(input int v, input int n, input bit s);
        ev_t e;
        e.v = 3'(v);
        e.n = 4'(n);
        e.s = s;
        return e;
    endfunction

    function automatic step_t mk(input int km, input int nev, input ev_t e0, input ev_t e1,
                                 input ev_t e2, input int notes, input int gate, input int cnt);
        step_t s;
        s.km    = NK'(km);
        s.nev   = 2'(nev);
        s.e0    = e0;
        s.e1    = e1;
        s.e2    = e2;
        s.notes = 16'(notes);
        s.gate  = 4'(gate);
        s.cnt   = 4'(cnt);
        return s;
    endfunction

    // Edges since reset release; edge n processes key (n-1) mod NK.
    always @(posedge clk or posedge ar) begin
        if (ar) cyc <= 0;
        else    cyc <= cyc + 1;
    end

    // Monitor: every trig pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!ar && mon_en) begin
            if (voice_trig != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_trig", 32'(voice_trig), 32'd0);
                end else begin
                    got = exp_q.pop_front();
                    chk("trig_voice", 32'(voice_trig), 32'(1) << got.v);
                    chk("trig_note", 32'(voice_note[4*int'(got.v) +: 4]), 32'(got.n));
                    chk("trig_steal", 32'(steal), 32'(got.s));
                end
            end else begin
                chk("steal_without_trig", 32'(steal), 32'd0);
            end
        end
    end

    // Wait until driving now makes the synchronised mask reach the scanner exactly at key 0.
    task automatic align_scan();
        do @(negedge clk); while ((cyc % NK) != NK - 2);
    endtask

    task automatic check_state(input string tag, input logic [15:0] notes,
                               input logic [3:0] gate, input logic [3:0] cnt);
        chk({tag, "_gate"},  32'(voice_gate),   32'(gate));
        chk({tag, "_count"}, 32'(active_count), 32'(cnt));
        chk({tag, "_notes"}, 32'(voice_note),   32'(notes));
    endtask

    task automatic run_step(input step_t s);
        align_scan();
        key_mask = s.km;
        if (s.nev > 0) exp_q.push_back(s.e0);
        if (s.nev > 1) exp_q.push_back(s.e1);
        if (s.nev > 2) exp_q.push_back(s.e2);
        repeat (16) @(negedge clk);
        chk("events_within_latency", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (10) @(negedge clk);
        check_state("step", s.notes, s.gate, s.cnt);
    endtask

    ev_t z;

    initial begin
        z = ev(0, 0, 0);
        //              km      nev  e0            e1            e2            notes   gate  cnt
        tbl[0]  = mk(16'h0001, 1, ev(0, 0, 0),  z,            z,            16'h0000, 4'h1, 1);
        tbl[1]  = mk(16'h0000, 0, z,            z,            z,            16'h0000, 4'h0, 0);
        tbl[2]  = mk(16'h0015, 3, ev(0, 0, 0),  ev(1, 2, 0),  ev(2, 4, 0),  16'h0420, 4'h7, 3);
        tbl[3]  = mk(16'h0000, 0, z,            z,            z,            16'h0420, 4'h0, 0);
        tbl[4]  = mk(16'h0002, 1, ev(0, 1, 0),  z,            z,            16'h0421, 4'h1, 1);
        tbl[5]  = mk(16'h000A, 1, ev(1, 3, 0),  z,            z,            16'h0431, 4'h3, 2);
        tbl[6]  = mk(16'h002A, 1, ev(2, 5, 0),  z,            z,            16'h0531, 4'h7, 3);
        tbl[7]  = mk(16'h00AA, 1, ev(3, 7, 0),  z,            z,            16'h7531, 4'hF, 4);
        tbl[8]  = mk(16'h02AA, 1, ev(0, 9, 1),  z,            z,            16'h7539, 4'hF, 4);
        tbl[9]  = mk(16'h02A8, 0, z,            z,            z,            16'h7539, 4'hF, 4);
        tbl[10] = mk(16'h00A8, 0, z,            z,            z,            16'h7539, 4'hE, 3);
        tbl[11] = mk(16'h10A8, 1, ev(0, 12, 0), z,            z,            16'h753C, 4'hF, 4);
        tbl[12] = mk(16'h00A8, 0, z,            z,            z,            16'h753C, 4'hE, 3);
        tbl[13] = mk(16'h10A8, 1, ev(0, 12, 0), z,            z,            16'h753C, 4'hF, 4);
        tbl[14] = mk(16'h0000, 0, z,            z,            z,            16'h753C, 4'h0, 0);
        tbl[15] = mk(16'h0005, 2, ev(0, 0, 0),  ev(1, 2, 0),  z,            16'h7520, 4'h3, 2);

        // Power-on reset
        repeat (3) @(negedge clk);
        check_state("reset", 16'h0000, 4'h0, 4'h0);
        chk("reset_trig",  32'(voice_trig), 32'd0);
        chk("reset_steal", 32'(steal),      32'd0);
        ar = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_step(tbl[i]);
            // Key 0 held steadily: the monitor flags any repeated trig.
            if (i == 0) repeat (50) @(negedge clk);
        end

        // Mid-scan reset with keys 0 and 2 still held.
        repeat (5) @(negedge clk);
        ar = 1'b1;
        #1;
        check_state("midreset", 16'h0000, 4'h0, 4'h0);
        chk("midreset_trig",  32'(voice_trig), 32'd0);
        chk("midreset_steal", 32'(steal),      32'd0);
        @(negedge clk);
        exp_q.delete();
        ar = 1'b0;
        // Scan restarts at key 0 before the synchroniser refills, so key 2 is seen first.
        exp_q.push_back(ev(0, 2, 0));
        exp_q.push_back(ev(1, 0, 0));
        repeat (16) @(negedge clk);
        chk("post_reset_events", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (10) @(negedge clk);
        check_state("post_reset", 16'h0002, 4'h3, 4'h2);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
